// File: rtl/sys_axi_w_buffer_if.sv
// AXI4 write-data (W) channel bundle.
// The master drives the beat, the slave drives ready.
interface sys_axi_w_buffer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    modport master (
        output wdata,
        output wstrb,
        output wlast,
        output wvalid,
        input  wready
    );

    modport slave (
        input  wdata,
        input  wstrb,
        input  wlast,
        input  wvalid,
        output wready
    );
endinterface

// File: rtl/sys_axi_w_buffer.sv
// AXI4 W-channel FIFO buffer.
// Optional store-and-forward: a burst is released only once its WLAST beat is held.
module sys_axi_w_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 8,
    parameter bit STORE_FWD  = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    sys_axi_w_buffer_if.slave        s_w,
    sys_axi_w_buffer_if.master       m_w,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   bursts_o,
    output logic                     long_burst_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + STRB_WIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [EW-1:0] mem_q [DEPTH];

    ptr_t wr_ptr_q;
    ptr_t wr_ptr_d;
    ptr_t rd_ptr_q;
    ptr_t rd_ptr_d;
    ptr_t level_q;
    ptr_t level_d;
    ptr_t bursts_q;
    ptr_t bursts_d;

    logic ready_q;
    logic ready_d;
    logic ovr_q;
    logic ovr_d;
    logic long_q;
    logic long_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          push_last;
    logic          pop_last;
    logic          ovr_set;
    logic          gate_open;
    logic [EW-1:0] head;

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    assign push      = s_w.wvalid & ready_q;
    assign pop       = m_w.wvalid & m_w.wready;
    assign push_last = push & s_w.wlast;
    assign pop_last  = pop & head[0];

    // A burst longer than the FIFO can never complete inside it,
    // so the buffer falls back to cut-through until its WLAST leaves.
    assign ovr_set = STORE_FWD && full && (bursts_q == '0);

    assign gate_open = !STORE_FWD || (bursts_q != '0) ||
                       ovr_q || ovr_set;

    assign s_w.wready = ready_q;
    assign m_w.wvalid = !empty && gate_open;
    assign m_w.wdata  = head[EW-1 -: DATA_WIDTH];
    assign m_w.wstrb  = head[STRB_WIDTH:1];
    assign m_w.wlast  = head[0];

    assign level_o      = level_q;
    assign bursts_o     = bursts_q;
    assign long_burst_o = long_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + PW'(push) - PW'(pop);
        bursts_d = bursts_q;
        unique case ({push_last, pop_last})
            2'b10:   bursts_d = bursts_q + 1'b1;
            2'b01:   bursts_d = bursts_q - 1'b1;
            default: bursts_d = bursts_q;
        endcase
        // Ready is a flop: a pop never frees a slot in the same cycle.
        ready_d = (level_d != PW'(DEPTH));
        ovr_d   = ovr_q;
        if (pop_last) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        long_d = long_q | ovr_set;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            bursts_q <= '0;
            ready_q  <= 1'b0;
            ovr_q    <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            bursts_q <= bursts_d;
            ready_q  <= ready_d;
            ovr_q    <= ovr_d;
            long_q   <= long_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_w.wdata, s_w.wstrb, s_w.wlast};
        end
    end

    a_bursts_le_level: assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        bursts_q <= level_q
    );

    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        full |-> !push
    );

    a_valid_stable: assert property (
        @(posedge clk_i) disable iff (!arstn_i)
        (m_w.wvalid && !m_w.wready) |=>
            (m_w.wvalid && $stable(head))
    );

endmodule

// File: tb/tb_sys_axi_w_buffer.sv
// Bench for sys_axi_w_buffer: cut-through (inst 0) and store-and-forward (inst 1)
// checked against a queue model of the buffer contents.
module tb_sys_axi_w_buffer;

    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_wdata [2];
    logic [SW-1:0] s_wstrb [2];
    logic          s_wlast [2];
    logic          s_wvalid[2];
    logic          s_wready[2];
    logic [DW-1:0] m_wdata [2];
    logic [SW-1:0] m_wstrb [2];
    logic          m_wlast [2];
    logic          m_wvalid[2];
    logic          m_wready[2];
    logic [LW-1:0] level   [2];
    logic [LW-1:0] bursts  [2];
    logic          long_b  [2];
    bit            done    [2];

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [72:0] act,
                       input logic [72:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        sys_axi_w_buffer_if #(.DATA_WIDTH(DW)) s_if ();
        sys_axi_w_buffer_if #(.DATA_WIDTH(DW)) m_if ();

        assign s_if.wdata  = s_wdata[g];
        assign s_if.wstrb  = s_wstrb[g];
        assign s_if.wlast  = s_wlast[g];
        assign s_if.wvalid = s_wvalid[g];
        assign s_wready[g] = s_if.wready;
        assign m_wdata[g]  = m_if.wdata;
        assign m_wstrb[g]  = m_if.wstrb;
        assign m_wlast[g]  = m_if.wlast;
        assign m_wvalid[g] = m_if.wvalid;
        assign m_if.wready = m_wready[g];

        sys_axi_w_buffer #(
            .DATA_WIDTH(DW),
            .DEPTH     (DEPTH),
            .STORE_FWD (g == 1)
        ) dut (
            .clk_i       (clk),
            .arstn_i     (arstn),
            .s_w         (s_if),
            .m_w         (m_if),
            .level_o     (level[g]),
            .bursts_o    (bursts[g]),
            .long_burst_o(long_b[g])
        );

        // Model: ordered list of held beats plus the over-long-burst flags.
        logic [72:0] q[$];
        bit ovr = 0;
        bit lb  = 0;

        always @(posedge clk) begin
            if (!arstn) begin
                q.delete();
                ovr = 0;
                lb  = 0;
            end else begin
                if (m_wvalid[g] && m_wready[g]) begin
                    if (q.size() == 0) begin
                        chk("pop_when_empty", 1, 0);
                    end else begin
                        chk("pop_beat", {m_wdata[g], m_wstrb[g], m_wlast[g]}, q[0]);
                        if (q[0][0]) ovr = 0;
                        void'(q.pop_front());
                    end
                end
                if (s_wvalid[g] && s_wready[g])
                    q.push_back({s_wdata[g], s_wstrb[g], s_wlast[g]});
            end
        end

        always @(negedge clk) begin
            int  n;
            bit  full;
            bit  ev;
            if (arstn) begin
                n = 0;
                foreach (q[i]) n += int'(q[i][0]);
                full = (q.size() == DEPTH);
                ev = (q.size() != 0) &&
                     (g == 0 || n != 0 || ovr || (full && n == 0));
                chk("wready", s_wready[g], !full);
                chk("wvalid", m_wvalid[g], ev);
                chk("level", level[g], q.size());
                chk("bursts", bursts[g], n);
                chk("long_burst", long_b[g], lb);
                if (ev) chk("head", {m_wdata[g], m_wstrb[g], m_wlast[g]}, q[0]);
                if (g == 1 && full && n == 0) begin
                    ovr = 1;
                    lb  = 1;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int g, input logic [63:0] d, input logic l,
                        input int gap);
        bit acc;
        if (gap > 0) begin
            s_wvalid[g] = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_wvalid[g] = 1'b1;
        s_wdata[g]  = d;
        s_wstrb[g]  = 8'($urandom);
        s_wlast[g]  = l;
        for (int t = 0; t < 2000; t++) begin
            acc = s_wready[g];
            @(negedge clk);
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int g);
        int t;
        t = 0;
        s_wvalid[g] = 1'b0;
        m_wready[g] = 1'b1;
        while (level[g] != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", level[g], 0);
    endtask

    task automatic rnd_run(input int g, input int beats);
        int left;
        int i;
        left = 0;
        i = 0;
        while (i < beats || left != 0) begin
            if (left == 0)
                left = ($urandom_range(0, 15) == 0) ? 12 : $urandom_range(1, 8);
            left--;
            send(g, {$urandom, $urandom}, left == 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
            i++;
        end
        s_wvalid[g] = 1'b0;
        done[g] = 1'b1;
    endtask

    task automatic sink(input int g);
        while (!done[g]) begin
            m_wready[g] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=%0d exp=0", 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            s_wvalid[g] = 1'b1;
            s_wdata[g]  = '0;
            s_wstrb[g]  = '0;
            s_wlast[g]  = 1'b0;
            m_wready[g] = 1'b0;
            done[g]     = 1'b0;
        end
        arstn = 1'b0;

        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("rst_wready", s_wready[g], 0);
                chk("rst_wvalid", m_wvalid[g], 0);
            end
        end
        #2;
        arstn = 1'b1;
        s_wvalid[0] = 1'b0;
        s_wvalid[1] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rel_wready", s_wready[g], 1);
            chk("rel_level", level[g], 0);
        end

        // Cut-through ordering and one-cycle latency.
        m_wready[0] = 1'b1;
        send(0, 64'h11, 1'b0, 0);
        chk("ct_first_valid", m_wvalid[0], 1);
        chk("ct_first_data", m_wdata[0], 64'h11);
        send(0, 64'h22, 1'b0, 0);
        send(0, 64'h33, 1'b0, 0);
        send(0, 64'h44, 1'b1, 0);
        drain(0);

        // Full and backpressure.
        m_wready[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 64'h100 + 64'(i), i == 7, 0);
        chk("full_level", level[0], 8);
        chk("full_wready", s_wready[0], 0);
        s_wvalid[0] = 1'b1;
        s_wdata[0]  = 64'h108;
        s_wlast[0]  = 1'b1;
        @(negedge clk);
        chk("full_hold", level[0], 8);
        m_wready[0] = 1'b1;
        @(negedge clk);
        chk("resume_wready", s_wready[0], 1);
        chk("resume_level", level[0], 7);
        @(negedge clk);
        s_wvalid[0] = 1'b0;
        chk("pushpop_level", level[0], 7);
        drain(0);

        // Simultaneous push and pop, both carrying WLAST, at level 3.
        m_wready[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 64'h200 + 64'(i), 1'b1, 0);
        chk("pp_pre_level", level[0], 3);
        s_wvalid[0] = 1'b1;
        s_wdata[0]  = 64'h203;
        s_wlast[0]  = 1'b1;
        m_wready[0] = 1'b1;
        @(negedge clk);
        s_wvalid[0] = 1'b0;
        chk("pp_level", level[0], 3);
        chk("pp_bursts", bursts[0], 3);
        drain(0);

        // Store-and-forward holds a burst until WLAST is in.
        m_wready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1, 64'h11 * 64'(i + 1), i == 3, 1);
            if (i == 2) chk("sf_hold", m_wvalid[1], 0);
        end
        chk("sf_release", m_wvalid[1], 1);
        chk("sf_bursts", bursts[1], 1);
        drain(1);
        chk("sf_bursts_end", bursts[1], 0);

        // Over-long burst forces cut-through and sets the sticky flag.
        m_wready[1] = 1'b0;
        for (int i = 0; i < 8; i++) send(1, 64'h500 + 64'(i), 1'b0, 0);
        chk("ob_level", level[1], 8);
        chk("ob_valid", m_wvalid[1], 1);
        m_wready[1] = 1'b1;
        for (int i = 8; i < 12; i++) send(1, 64'h500 + 64'(i), i == 11, 0);
        drain(1);
        chk("ob_sticky", long_b[1], 1);

        fork
            rnd_run(0, 10000);
            rnd_run(1, 10000);
            sink(0);
            sink(1);
        join
        drain(0);
        drain(1);

        // Reset with a partial burst held discards everything.
        m_wready[1] = 1'b1;
        for (int i = 0; i < 3; i++) send(1, 64'h900 + 64'(i), 1'b0, 0);
        s_wvalid[1] = 1'b0;
        chk("mid_level", level[1], 3);
        #2;
        arstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", level[1], 0);
        chk("mid_rst_valid", m_wvalid[1], 0);
        chk("mid_rst_wready", s_wready[1], 0);
        chk("mid_rst_long", long_b[1], 0);
        #2;
        arstn = 1'b1;
        @(negedge clk);
        chk("mid_rel_wready", s_wready[1], 1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
